// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control path.
// Holds the major opcode constants (same values the instruction decoder uses),
// the controller FSM state encoding, writeback-source select codes, trap cause
// codes, and the per-instruction control bundle latched in DECODE.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd7
  } state_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ECALL   = 2'd1;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd2;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd3;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic branch;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter shared by the instruction-fetch and data-memory waits.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            restart the count (request completed or not waiting)
//   inc            a request cycle passed with ready still low
//   limit_reached  this waiting cycle is the LIMIT-th request cycle; the
//                  caller abandons the access unless ready is high now
// LIMIT = 0 disables the timeout entirely.
module mem_timeout_counter #(
  parameter int LIMIT = 0,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic limit_reached
);

  // The first request cycle sees a count of 0, so the LIMIT-th sees LIMIT-1.
  localparam logic [WIDTH-1:0] LAST = (LIMIT > 0) ? WIDTH'(LIMIT - 1) : '0;

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else if (clr)
      count_q <= '0;
    else if (inc)
      count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  assign limit_reached = (LIMIT != 0) && inc && (count_q == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I core: FETCH -> DECODE -> EXECUTE ->
// (MEM) -> (WRITEBACK) -> FETCH, with a sticky TRAP state.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req / imem_ready       instruction fetch handshake
//   dmem_req / dmem_we /
//   dmem_ready                  data memory handshake (we: 1 store, 0 load)
//   opcode, mem_to_reg,
//   mem_write_size, branch,
//   jump, decode_error          decoder control outputs, sampled in DECODE
//   branch_taken                comparator result, used in EXECUTE
//   ir_write, pc_write, pc_sel,
//   reg_write, wb_sel           datapath strobes and selects
//   state, halted, trap_cause   debug state, sticky trap flag and its cause
//   instret                     retired-instruction counter (wraps)
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int MEM_TIMEOUT   = 0,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  input  logic [6:0]           opcode,
  input  logic                 mem_to_reg,
  input  logic [1:0]           mem_write_size,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 decode_error,
  input  logic                 branch_taken,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_sel,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic [2:0]           state,
  output logic                 halted,
  output logic [1:0]           trap_cause,
  output logic [WORD_SIZE-1:0] instret
);

  state_e               state_q, state_d;
  ctrl_t                ctrl_q;
  logic [1:0]           cause_q, cause_d;
  logic [WORD_SIZE-1:0] instret_q;
  logic                 tmo_wait, tmo_limit;

  // A wait cycle is a request cycle whose ready is still low; any other
  // cycle (including the completing one) restarts the count.
  assign tmo_wait = ((state_q == ST_FETCH) && !imem_ready) ||
                    ((state_q == ST_MEM)   && !dmem_ready);

  mem_timeout_counter #(
    .LIMIT (MEM_TIMEOUT),
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (!tmo_wait),
    .inc           (tmo_wait),
    .limit_reached (tmo_limit)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;

    unique case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (tmo_limit) begin
          state_d = ST_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (decode_error) begin
          state_d = ST_TRAP;
          cause_d = TRAP_ILLEGAL;
        end else if (opcode == OP_SYSTEM) begin
          state_d = ST_TRAP;
          cause_d = TRAP_ECALL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (ctrl_q.branch) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken;
          state_d  = ST_FETCH;
        end else if (ctrl_q.is_load || ctrl_q.is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl_q.is_store;
        if (dmem_ready) begin
          if (ctrl_q.is_store) begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else if (tmo_limit) begin
          state_d = ST_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        reg_write = 1'b1;
        wb_sel    = ctrl_q.is_load ? WB_MEM : (ctrl_q.jump ? WB_PC4 : WB_ALU);
        pc_write  = 1'b1;
        pc_sel    = ctrl_q.jump;
        state_d   = ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // While reset is held the state register already reads FETCH; gating
    // here keeps the fetch request and all strobes low until release.
    if (!rst_n) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      cause_q   <= TRAP_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      // Every retirement is marked by the single PC update of that instruction.
      if (pc_write)
        instret_q <= instret_q + {{(WORD_SIZE-1){1'b0}}, 1'b1};
    end
  end

  // Control bundle is only consumed after DECODE has written it.
  always_ff @(posedge clk) begin
    if (state_q == ST_DECODE) begin
      ctrl_q.is_load  <= mem_to_reg;
      ctrl_q.is_store <= |mem_write_size;
      ctrl_q.branch   <= branch;
      ctrl_q.jump     <= jump;
    end
  end

  assign state      = state_q;
  assign halted     = (state_q == ST_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [6:0]  opcode;
  logic        mem_to_reg;
  logic [1:0]  mem_write_size;
  logic        branch, jump, decode_error, branch_taken;
  logic        ir_write, pc_write, pc_sel, reg_write;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        halted;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  multicycle_controller #(
    .WORD_SIZE     (32),
    .MEM_TIMEOUT   (4),
    .TIMEOUT_WIDTH (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_ready     (imem_ready),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_ready     (dmem_ready),
    .opcode         (opcode),
    .mem_to_reg     (mem_to_reg),
    .mem_write_size (mem_write_size),
    .branch         (branch),
    .jump           (jump),
    .decode_error   (decode_error),
    .branch_taken   (branch_taken),
    .ir_write       (ir_write),
    .pc_write       (pc_write),
    .pc_sel         (pc_sel),
    .reg_write      (reg_write),
    .wb_sel         (wb_sel),
    .state          (state),
    .halted         (halted),
    .trap_cause     (trap_cause),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outcome of one instruction, pushed before it is driven.
  typedef struct {
    int         ret_cycle;   // cycle index of the pc_write, -1 if none
    bit         pc_sel;
    bit         reg_write;
    logic [1:0] wb_sel;
    int         dreq;        // cycles with dmem_req high
    bit         dwe;
    bit         trapped;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  // Observations gathered by run_instr.
  int         obs_ret, obs_dreq, obs_rw_count;
  bit         obs_pcsel, obs_rw, obs_dwe, obs_trap, obs_ir0;
  logic [1:0] obs_wb;
  logic [31:0] instret_before;

  task automatic push_exp(input int rc, input bit ps, input bit rw, input logic [1:0] wb,
                          input int dq, input bit dw, input bit tr);
    exp_t x;
    x.ret_cycle = rc; x.pc_sel = ps; x.reg_write = rw; x.wb_sel = wb;
    x.dreq = dq; x.dwe = dw; x.trapped = tr;
    exp_q.push_back(x);
  endtask

  // Drives one instruction from FETCH until retirement or trap; dly is the
  // number of dmem_req cycles before dmem_ready rises (-1 = never).
  task automatic run_instr(input logic [6:0] op, input bit ld, input bit st, input bit br,
                           input bit jp, input bit err, input bit taken, input int dly);
    int  dcount;
    bit  done;
    opcode = op; mem_to_reg = ld; mem_write_size = st ? 2'b10 : 2'b00;
    branch = br; jump = jp; decode_error = err; branch_taken = taken;
    imem_ready = 1'b1;
    obs_ret = -1; obs_dreq = 0; obs_rw_count = 0; obs_pcsel = 0; obs_rw = 0;
    obs_wb = 2'b00; obs_dwe = 0; obs_trap = 0; obs_ir0 = 0;
    dcount = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_ready = dmem_req && (dly >= 0) && (dcount == dly);
      @(negedge clk);
      if (c == 0) obs_ir0 = ir_write;
      if (dmem_req) begin dcount++; obs_dwe |= dmem_we; end
      if (reg_write) obs_rw_count++;
      if (pc_write) begin
        obs_ret = c; obs_pcsel = pc_sel; obs_rw = reg_write; obs_wb = wb_sel; done = 1;
      end
      if (halted) begin obs_trap = 1; done = 1; end
      @(posedge clk); #1;
    end
    obs_dreq = dcount;
    dmem_ready = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0;
    opcode = OP_OP; mem_to_reg = 0; mem_write_size = 0; branch = 0; jump = 0;
    decode_error = 0; branch_taken = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (imem_req !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req imem=%b dmem=%b exp=0", imem_req, dmem_req); end
    checks++; if (halted !== 1'b0 || trap_cause !== 2'd0) begin errors++; $display("FAIL reset_trap halted=%b cause=%0d exp=0", halted, trap_cause); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    checks++; if (ir_write !== 1'b0 || pc_write !== 1'b0 || reg_write !== 1'b0) begin errors++; $display("FAIL reset_strobes ir=%b pc=%b rw=%b exp=0", ir_write, pc_write, reg_write); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_imem_req got=%b exp=1", imem_req); end
    // Still in the first fetch; let the next instruction task take it over.
    @(posedge clk); #1;
    run_instr(OP_OP, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_add();
    instret_before = instret;
    push_exp(3, 0, 1, WB_ALU, 0, 0, 0);
    run_instr(OP_OP, 0, 0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    checks++; if (obs_ir0 !== 1'b1) begin errors++; $display("FAIL add_ir_write got=%b exp=1", obs_ir0); end
    checks++; if (obs_ret !== e.ret_cycle) begin errors++; $display("FAIL add_latency got=%0d exp=%0d", obs_ret, e.ret_cycle); end
    checks++; if (obs_rw !== e.reg_write || obs_wb !== e.wb_sel || obs_pcsel !== e.pc_sel) begin errors++; $display("FAIL add_wb rw=%b wb=%0d psel=%b exp rw=%b wb=%0d psel=%b", obs_rw, obs_wb, obs_pcsel, e.reg_write, e.wb_sel, e.pc_sel); end
    checks++; if (instret !== instret_before + 32'd1) begin errors++; $display("FAIL add_instret got=%0d exp=%0d", instret, instret_before + 32'd1); end
  endtask

  task automatic test_load();
    instret_before = instret;
    push_exp(7, 0, 1, WB_MEM, 4, 0, 0);
    run_instr(OP_LOAD, 1, 0, 0, 0, 0, 0, 3);
    e = exp_q.pop_front();
    checks++; if (obs_dreq !== e.dreq || obs_dwe !== e.dwe) begin errors++; $display("FAIL lw_dmem dreq=%0d we=%b exp dreq=%0d we=%b", obs_dreq, obs_dwe, e.dreq, e.dwe); end
    checks++; if (obs_ret !== e.ret_cycle) begin errors++; $display("FAIL lw_latency got=%0d exp=%0d", obs_ret, e.ret_cycle); end
    checks++; if (obs_rw !== e.reg_write || obs_wb !== e.wb_sel) begin errors++; $display("FAIL lw_wb rw=%b wb=%0d exp rw=%b wb=%0d", obs_rw, obs_wb, e.reg_write, e.wb_sel); end
    checks++; if (instret !== instret_before + 32'd1) begin errors++; $display("FAIL lw_instret got=%0d exp=%0d", instret, instret_before + 32'd1); end
  endtask

  task automatic test_branch();
    push_exp(2, 1, 0, WB_ALU, 0, 0, 0);
    run_instr(OP_BRANCH, 0, 0, 1, 0, 0, 1, 0);
    e = exp_q.pop_front();
    checks++; if (obs_ret !== e.ret_cycle || obs_pcsel !== e.pc_sel) begin errors++; $display("FAIL beq_taken ret=%0d psel=%b exp ret=%0d psel=%b", obs_ret, obs_pcsel, e.ret_cycle, e.pc_sel); end
    checks++; if (obs_rw_count !== 0) begin errors++; $display("FAIL beq_no_regwrite got=%0d exp=0", obs_rw_count); end
    push_exp(2, 0, 0, WB_ALU, 0, 0, 0);
    run_instr(OP_BRANCH, 0, 0, 1, 0, 0, 0, 0);
    e = exp_q.pop_front();
    checks++; if (obs_ret !== e.ret_cycle || obs_pcsel !== e.pc_sel) begin errors++; $display("FAIL bne_not_taken ret=%0d psel=%b exp ret=%0d psel=%b", obs_ret, obs_pcsel, e.ret_cycle, e.pc_sel); end
    checks++; if (obs_rw_count !== 0) begin errors++; $display("FAIL bne_no_regwrite got=%0d exp=0", obs_rw_count); end
  endtask

  task automatic test_jal();
    push_exp(3, 1, 1, WB_PC4, 0, 0, 0);
    run_instr(OP_JAL, 0, 0, 0, 1, 0, 0, 0);
    e = exp_q.pop_front();
    checks++; if (obs_ret !== e.ret_cycle) begin errors++; $display("FAIL jal_latency got=%0d exp=%0d", obs_ret, e.ret_cycle); end
    checks++; if (obs_rw !== e.reg_write || obs_wb !== e.wb_sel || obs_pcsel !== e.pc_sel) begin errors++; $display("FAIL jal_wb rw=%b wb=%0d psel=%b exp rw=%b wb=%0d psel=%b", obs_rw, obs_wb, obs_pcsel, e.reg_write, e.wb_sel, e.pc_sel); end
  endtask

  task automatic test_store_fast();
    push_exp(3, 0, 0, WB_ALU, 1, 1, 0);
    run_instr(OP_STORE, 0, 1, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    checks++; if (obs_ret !== e.ret_cycle || obs_pcsel !== e.pc_sel) begin errors++; $display("FAIL sw_fast ret=%0d psel=%b exp ret=%0d psel=%b", obs_ret, obs_pcsel, e.ret_cycle, e.pc_sel); end
    checks++; if (obs_dreq !== e.dreq || obs_dwe !== e.dwe || obs_rw_count !== 0) begin errors++; $display("FAIL sw_fast_dmem dreq=%0d we=%b rw=%0d exp dreq=%0d we=%b rw=0", obs_dreq, obs_dwe, obs_rw_count, e.dreq, e.dwe); end
  endtask

  task automatic test_illegal();
    int stray;
    instret_before = instret;
    push_exp(-1, 0, 0, WB_ALU, 0, 0, 1);
    run_instr(7'b1111111, 0, 0, 0, 0, 1, 0, 0);
    e = exp_q.pop_front();
    checks++; if (obs_trap !== e.trapped || trap_cause !== TRAP_ILLEGAL) begin errors++; $display("FAIL illegal_trap halted=%b cause=%0d exp halted=1 cause=2", obs_trap, trap_cause); end
    checks++; if (instret !== instret_before) begin errors++; $display("FAIL illegal_instret got=%0d exp=%0d", instret, instret_before); end
    stray = 0;
    dmem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req || dmem_req || ir_write || pc_write || reg_write || !halted) stray++;
    end
    dmem_ready = 1'b0;
    checks++; if (stray !== 0 || state !== 3'd7) begin errors++; $display("FAIL trap_absorbing stray=%0d state=%0d exp stray=0 state=7", stray, state); end
    rst_n = 1'b0;
    #2;
    checks++; if (state !== 3'd0 || instret !== 32'd0 || halted !== 1'b0 || trap_cause !== 2'd0) begin errors++; $display("FAIL trap_reset state=%0d instret=%0d halted=%b cause=%0d exp 0", state, instret, halted, trap_cause); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_ecall();
    push_exp(-1, 0, 0, WB_ALU, 0, 0, 1);
    run_instr(OP_SYSTEM, 0, 0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    checks++; if (obs_trap !== e.trapped || trap_cause !== TRAP_ECALL) begin errors++; $display("FAIL ecall_trap halted=%b cause=%0d exp halted=1 cause=1", obs_trap, trap_cause); end
    reset_pulse();
  endtask

  task automatic test_reset_mid_access();
    opcode = OP_LOAD; mem_to_reg = 1; mem_write_size = 0; branch = 0; jump = 0;
    decode_error = 0; branch_taken = 0; imem_ready = 1'b1; dmem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL midreset_setup dmem_req=%b exp=1", dmem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || pc_write !== 1'b0 || reg_write !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL midreset_drop dreq=%b pcw=%b rw=%b state=%0d exp 0", dmem_req, pc_write, reg_write, state); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    instret_before = instret;
    push_exp(-1, 0, 0, WB_ALU, 4, 1, 1);
    run_instr(OP_STORE, 0, 1, 0, 0, 0, 0, -1);
    e = exp_q.pop_front();
    checks++; if (obs_trap !== e.trapped || trap_cause !== TRAP_TIMEOUT) begin errors++; $display("FAIL timeout_trap halted=%b cause=%0d exp halted=1 cause=3", obs_trap, trap_cause); end
    checks++; if (obs_dreq !== e.dreq || instret !== instret_before) begin errors++; $display("FAIL timeout_req dreq=%0d instret=%0d exp dreq=%0d instret=%0d", obs_dreq, instret, e.dreq, instret_before); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL timeout_req_drop got=%b exp=0", dmem_req); end
    reset_pulse();
    push_exp(6, 0, 0, WB_ALU, 4, 1, 0);
    run_instr(OP_STORE, 0, 1, 0, 0, 0, 0, 3);
    e = exp_q.pop_front();
    checks++; if (obs_trap !== e.trapped || obs_ret !== e.ret_cycle || obs_dreq !== e.dreq) begin errors++; $display("FAIL timeout_edge trap=%b ret=%0d dreq=%0d exp trap=0 ret=%0d dreq=%0d", obs_trap, obs_ret, obs_dreq, e.ret_cycle, e.dreq); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL timeout_edge_instret got=%0d exp=1", instret); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_jal();
    test_store_fast();
    test_illegal();
    test_ecall();
    test_reset_mid_access();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
